// File: rtl/reg_dump_reader.sv
// Halts the pipeline, then streams every register of the bank out as bytes,
// register 0 upward, least significant byte of each word first.
module reg_dump_reader #(
    parameter int REG_WIDTH     = 32,
    parameter int REG_ADDR_BITS = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    output logic                     halt_req,
    input  logic                     halt_ack,
    output logic [REG_ADDR_BITS-1:0] rd_addr,
    input  logic [REG_WIDTH-1:0]     rd_data,
    output logic [7:0]               tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic                     busy,
    output logic                     done
);

    localparam int NBYTES = REG_WIDTH / 8;
    localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [REG_ADDR_BITS-1:0] ADDR_MAX = {REG_ADDR_BITS{1'b1}};

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        RD0,
        RD1,
        SEND
    } state_t;

    state_t               state;
    state_t               next_state;
    logic [REG_WIDTH-1:0] shift_reg;
    logic [CNT_W-1:0]     byte_cnt;
    logic                 last_byte;
    logic                 transfer;

    assign last_byte = (byte_cnt == CNT_W'(NBYTES - 1));
    assign transfer  = (state == SEND) && tx_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start)    next_state = HALT;
            HALT: if (halt_ack) next_state = RD0;
            RD0:                next_state = RD1;
            RD1:                next_state = SEND;
            SEND: begin
                if (transfer && last_byte) begin
                    next_state = (rd_addr == ADDR_MAX) ? IDLE : RD0;
                end
            end
            default:            next_state = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != IDLE);
        halt_req = (state != IDLE);
        tx_valid = (state == SEND);
        tx_data  = shift_reg[7:0];
    end

    // The low byte of shift_reg is always the byte on offer; each accepted
    // byte shifts the next one down without a bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_addr   <= '0;
            shift_reg <= '0;
            byte_cnt  <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) rd_addr <= '0;
                end
                HALT: begin
                    if (halt_ack) rd_addr <= '0;
                end
                RD1: begin
                    shift_reg <= rd_data;
                    byte_cnt  <= '0;
                end
                SEND: begin
                    if (transfer) begin
                        if (last_byte) begin
                            if (rd_addr == ADDR_MAX) begin
                                done <= 1'b1;
                            end else begin
                                rd_addr <= rd_addr + REG_ADDR_BITS'(1);
                            end
                        end else begin
                            shift_reg <= shift_reg >> 8;
                            byte_cnt  <= byte_cnt + CNT_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed bench for reg_dump_reader: a bank model holding 0x0A0B0C00+i, with
// each scenario in its own task checking the byte stream and handshakes.
module tb_reg_dump_reader;

    localparam int REG_WIDTH     = 32;
    localparam int REG_ADDR_BITS = 5;
    localparam int NUM_REGS      = 32;
    localparam int NUM_BYTES     = 128;
    localparam int BASIC_DONE_CYC = 193;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     start;
    logic                     halt_req;
    logic                     halt_ack;
    logic [REG_ADDR_BITS-1:0] rd_addr;
    logic [REG_WIDTH-1:0]     rd_data;
    logic [7:0]               tx_data;
    logic                     tx_valid;
    logic                     tx_ready;
    logic                     busy;
    logic                     done;

    logic [REG_WIDTH-1:0] bank [NUM_REGS];

    int errors = 0;
    int checks = 0;

    logic [7:0] got_bytes [$];
    int         done_pulses;
    int         stall_errs;
    int         done_cycle;
    bit         timed_out;

    always #5 clk = ~clk;

    always @(posedge clk) rd_data <= bank[rd_addr];

    reg_dump_reader #(
        .REG_WIDTH    (REG_WIDTH),
        .REG_ADDR_BITS(REG_ADDR_BITS)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .halt_req(halt_req),
        .halt_ack(halt_ack),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .busy    (busy),
        .done    (done)
    );

    function automatic logic [7:0] exp_byte(input int n);
        logic [31:0] w;
        w = 32'h0A0B0C00 + 32'(n / 4);
        return w[(n % 4) * 8 +: 8];
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Runs one dump from IDLE and records bytes, done pulses and stall stability.
    task automatic drive_dump(input bit random_ready, input bit start_in_send);
        logic [7:0] prev_data;
        bit         prev_stall;
        bit         ready;
        bit         seen_done;
        int         post;
        got_bytes.delete();
        done_pulses = 0;
        stall_errs  = 0;
        done_cycle  = -1;
        timed_out   = 1'b1;
        prev_stall  = 1'b0;
        prev_data   = 8'h00;
        seen_done   = 1'b0;
        post        = 0;
        start    = 1'b1;
        halt_ack = 1'b1;
        tx_ready = 1'b0;
        @(negedge clk);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (done === 1'b1) begin
                done_pulses++;
                if (!seen_done) done_cycle = cyc;
                seen_done = 1'b1;
            end
            if (prev_stall && (tx_valid !== 1'b1 || tx_data !== prev_data)) stall_errs++;
            if (seen_done) begin
                post++;
                if (post > 4) begin
                    timed_out = 1'b0;
                    break;
                end
            end
            ready    = random_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
            tx_ready = ready;
            start    = (start_in_send && tx_valid === 1'b1);
            if (tx_valid === 1'b1 && ready) got_bytes.push_back(tx_data);
            prev_stall = (tx_valid === 1'b1) && !ready;
            prev_data  = tx_data;
            @(negedge clk);
        end
        start    = 1'b0;
        tx_ready = 1'b0;
    endtask

    task automatic test_reset();
        start    = 1'b1;
        halt_ack = 1'b1;
        tx_ready = 1'b1;
        reset    = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0)     begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0)     begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        checks++; if (halt_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_halt_req: got %b expected 0", halt_req); end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_tx_valid: got %b expected 0", tx_valid); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_tx_data: got %h expected 00", tx_data); end
        checks++; if (rd_addr !== '0)    begin errors++; $display("[TB] FAIL reset_rd_addr: got %h expected 00", rd_addr); end
        start    = 1'b0;
        tx_ready = 1'b0;
        reset    = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_latency();
        start    = 1'b1;
        halt_ack = 1'b1;
        tx_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        checks++; if (halt_req !== 1'b1 || busy !== 1'b1) begin errors++; $display("[TB] FAIL lat_e0_halt: got halt_req=%b busy=%b expected 1 1", halt_req, busy); end
        @(negedge clk);
        checks++; if (rd_addr !== '0 || tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL lat_e1_addr: got rd_addr=%h tx_valid=%b expected 00 0", rd_addr, tx_valid); end
        @(negedge clk);
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL lat_e2_valid: got %b expected 0", tx_valid); end
        @(negedge clk);
        checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h00) begin errors++; $display("[TB] FAIL lat_e3_byte: got valid=%b data=%h expected 1 00", tx_valid, tx_data); end
        @(negedge clk);
        checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h00) begin errors++; $display("[TB] FAIL lat_hold: got valid=%b data=%h expected 1 00", tx_valid, tx_data); end
        do_reset();
    endtask

    task automatic test_basic_dump();
        drive_dump(1'b0, 1'b0);
        checks++; if (timed_out !== 1'b0) begin errors++; $display("[TB] FAIL basic_timeout: got timed_out=%b expected 0", timed_out); end
        checks++; if (got_bytes.size() != NUM_BYTES) begin errors++; $display("[TB] FAIL basic_count: got %0d expected %0d", got_bytes.size(), NUM_BYTES); end
        for (int n = 0; n < got_bytes.size() && n < NUM_BYTES; n++) begin
            checks++;
            if (got_bytes[n] !== exp_byte(n)) begin errors++; $display("[TB] FAIL basic_byte[%0d]: got %h expected %h", n, got_bytes[n], exp_byte(n)); end
        end
        checks++; if (done_pulses != 1) begin errors++; $display("[TB] FAIL basic_done_pulses: got %0d expected 1", done_pulses); end
        checks++; if (done_cycle != BASIC_DONE_CYC) begin errors++; $display("[TB] FAIL basic_done_cycle: got %0d expected %0d", done_cycle, BASIC_DONE_CYC); end
        checks++; if (busy !== 1'b0 || halt_req !== 1'b0) begin errors++; $display("[TB] FAIL basic_idle_after: got busy=%b halt_req=%b expected 0 0", busy, halt_req); end
        checks++; if (rd_addr !== 5'h1F) begin errors++; $display("[TB] FAIL basic_no_wrap: got rd_addr=%h expected 1f", rd_addr); end
    endtask

    task automatic test_backpressure();
        drive_dump(1'b1, 1'b0);
        checks++; if (timed_out !== 1'b0) begin errors++; $display("[TB] FAIL bp_timeout: got timed_out=%b expected 0", timed_out); end
        checks++; if (stall_errs != 0) begin errors++; $display("[TB] FAIL bp_stall_stable: got %0d unstable cycles expected 0", stall_errs); end
        checks++; if (got_bytes.size() != NUM_BYTES) begin errors++; $display("[TB] FAIL bp_count: got %0d expected %0d", got_bytes.size(), NUM_BYTES); end
        for (int n = 0; n < got_bytes.size() && n < NUM_BYTES; n++) begin
            checks++;
            if (got_bytes[n] !== exp_byte(n)) begin errors++; $display("[TB] FAIL bp_byte[%0d]: got %h expected %h", n, got_bytes[n], exp_byte(n)); end
        end
        checks++; if (done_pulses != 1) begin errors++; $display("[TB] FAIL bp_done_pulses: got %0d expected 1", done_pulses); end
    endtask

    task automatic test_halt_wait();
        int viol;
        viol     = 0;
        start    = 1'b1;
        halt_ack = 1'b0;
        tx_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (halt_req !== 1'b1 || busy !== 1'b1 || tx_valid !== 1'b0 || rd_addr !== '0) viol++;
            @(negedge clk);
        end
        checks++; if (viol != 0) begin errors++; $display("[TB] FAIL halt_wait_hold: got %0d bad cycles expected 0", viol); end
        halt_ack = 1'b1;
        @(negedge clk);
        checks++; if (tx_valid !== 1'b0 || rd_addr !== '0) begin errors++; $display("[TB] FAIL halt_wait_rd0: got valid=%b rd_addr=%h expected 0 00", tx_valid, rd_addr); end
        @(negedge clk);
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL halt_wait_rd1: got valid=%b expected 0", tx_valid); end
        @(negedge clk);
        checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h00) begin errors++; $display("[TB] FAIL halt_wait_send: got valid=%b data=%h expected 1 00", tx_valid, tx_data); end
        tx_ready = 1'b0;
        do_reset();
    endtask

    task automatic test_reset_mid_dump();
        int sent;
        bit found;
        sent     = 0;
        found    = 1'b0;
        start    = 1'b1;
        halt_ack = 1'b1;
        tx_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 400 && !found; cyc++) begin
            if (tx_valid === 1'b1) begin
                if (sent == 22) found = 1'b1;
                else sent++;
            end
            if (!found) @(negedge clk);
        end
        checks++; if (found !== 1'b1 || tx_data !== 8'h0B) begin errors++; $display("[TB] FAIL mid_reg5_byte2: got found=%b data=%h expected 1 0b", found, tx_data); end
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        tx_ready = 1'b0;
        checks++; if (tx_valid !== 1'b0 || busy !== 1'b0 || halt_req !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_clear: got valid=%b busy=%b halt_req=%b expected 0 0 0", tx_valid, busy, halt_req); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_no_resume: got busy=%b expected 0", busy); end
        drive_dump(1'b0, 1'b0);
        checks++; if (got_bytes.size() != NUM_BYTES) begin errors++; $display("[TB] FAIL mid_restart_count: got %0d expected %0d", got_bytes.size(), NUM_BYTES); end
        for (int n = 0; n < got_bytes.size() && n < NUM_BYTES; n++) begin
            checks++;
            if (got_bytes[n] !== exp_byte(n)) begin errors++; $display("[TB] FAIL mid_restart_byte[%0d]: got %h expected %h", n, got_bytes[n], exp_byte(n)); end
        end
        checks++; if (done_pulses != 1) begin errors++; $display("[TB] FAIL mid_restart_done: got %0d expected 1", done_pulses); end
    endtask

    task automatic test_ignored_start();
        drive_dump(1'b0, 1'b1);
        checks++; if (got_bytes.size() != NUM_BYTES) begin errors++; $display("[TB] FAIL ign_start_count: got %0d expected %0d", got_bytes.size(), NUM_BYTES); end
        checks++; if (done_pulses != 1) begin errors++; $display("[TB] FAIL ign_start_done: got %0d expected 1", done_pulses); end
        checks++; if (done_cycle != BASIC_DONE_CYC) begin errors++; $display("[TB] FAIL ign_start_timing: got %0d expected %0d", done_cycle, BASIC_DONE_CYC); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL ign_start_idle: got busy=%b expected 0", busy); end
    endtask

    initial begin
        for (int i = 0; i < NUM_REGS; i++) bank[i] = 32'h0A0B0C00 + 32'(i);
        reset    = 1'b0;
        start    = 1'b0;
        halt_ack = 1'b0;
        tx_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_latency();
        test_basic_dump();
        test_backpressure();
        test_halt_wait();
        test_reset_mid_dump();
        test_ignored_start();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_dump_reader.md
REG_DUMP_READER -- requirements
Module: reg_dump_reader

Interface
REQ-001 SHALL have parameter REG_WIDTH, default 32, meaning the register bank word width (multiple of 8).
REQ-002 SHALL have parameter REG_ADDR_BITS, default 5, meaning the register bank address width (2**REG_ADDR_BITS registers).
REQ-003 SHALL use one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock.
REQ-004 SHALL have reset  input  1  synchronous active-high reset.
REQ-005 SHALL have start  input  1  request one full register dump; sampled in IDLE only.
REQ-006 SHALL have halt_req  output  1  asks the pipeline to stop and hold write_w low.
REQ-007 SHALL have halt_ack  input  1  pipeline confirms it is stopped.
REQ-008 SHALL have rd_addr  output  REG_ADDR_BITS  drives the register bank read address port.
REQ-009 SHALL have rd_data  input  REG_WIDTH  registered read data from the register bank (1-cycle read latency).
REQ-010 SHALL have tx_data  output  8  byte to the serial transmitter.
REQ-011 SHALL have tx_valid  output  1  tx_data holds a valid byte.
REQ-012 SHALL have tx_ready  input  1  transmitter accepts the byte on this edge.
REQ-013 SHALL have busy  output  1  dump in progress (any state other than IDLE).
REQ-014 SHALL have done  output  1  one-cycle pulse after the final byte is accepted.

Function
REQ-015 SHALL implement states IDLE, HALT, RD0, RD1, SEND.
REQ-016 IDLE: on an edge with start=1, SHALL go to HALT with busy=1 and halt_req=1; start in any other state SHALL be ignored.
REQ-017 HALT: SHALL remain until an edge with halt_ack=1, then go to RD0 with rd_addr=0.
REQ-018 RD0: SHALL go to RD1 on the next edge (the bank samples rd_addr).
REQ-019 RD1: on the next edge SHALL load rd_data into a shift register, set byte counter to 0, set tx_valid=1, set tx_data=rd_data[7:0], and go to SEND.
REQ-020 Byte order SHALL be little-endian: byte k = word[8k+7:8k], k = 0..REG_WIDTH/8-1.
REQ-021 A byte SHALL transfer only on an edge with tx_valid=1 and tx_ready=1; tx_data SHALL stay stable while tx_valid=1 and tx_ready=0.
REQ-022 SEND, on a transfer that is not the last byte of the word: SHALL present the next byte with tx_valid=1 on the following cycle, with no bubble.
REQ-023 SEND, on a transfer of the last byte of a word when rd_addr < 2**REG_ADDR_BITS-1: SHALL clear tx_valid, increment rd_addr, and go to RD0, giving a 2-cycle gap between words.
REQ-024 SEND, on a transfer of the last byte of the word at rd_addr = 2**REG_ADDR_BITS-1: SHALL clear tx_valid, busy and halt_req, pulse done=1 for exactly one cycle, and go to IDLE; rd_addr SHALL NOT wrap.
REQ-025 halt_req SHALL stay 1 from HALT until the end of the dump; halt_ack falling mid-dump SHALL NOT be handled (integration guarantees it stays high).
REQ-026 A dump SHALL emit exactly (2**REG_ADDR_BITS)*(REG_WIDTH/8) bytes, 128 with default parameters, in register order 0 upward.
REQ-027 tx_ready while tx_valid=0 SHALL be ignored.
REQ-028 A start in the same edge as done SHALL be ignored; a new dump needs start while IDLE.

Reset
REQ-029 reset=1 at an edge SHALL force IDLE from any state with busy=0, done=0, halt_req=0, tx_valid=0, tx_data=0, rd_addr=0, shift register=0, byte counter=0.
REQ-030 reset SHALL take priority over start, halt_ack and tx_ready on the same edge; a dump aborted by reset SHALL NOT be resumed.

Verification
REQ-031 Basic dump: bank reg[i]=32'h0A0B0C00+i, halt_ack tied 1, tx_ready tied 1, start pulse -> 128 bytes 00,0C,0B,0A,01,0C,0B,0A,... ending 1F,0C,0B,0A; a single done pulse; busy=0 afterwards.
REQ-032 Latency: start at edge E0, halt_ack=1 -> halt_req=1 after E0, rd_addr=0 after E1, tx_valid=1 with byte 00 after E3.
REQ-033 Backpressure: tx_ready toggles pseudo-randomly -> tx_data stable while stalled, no byte lost or duplicated, same 128-byte sequence as REQ-031.
REQ-034 Halt wait: halt_ack held 0 for 10 cycles -> stays in HALT with rd_addr not driven past 0 and tx_valid=0; proceeds 1 cycle after halt_ack=1.
REQ-035 Reset mid-dump: reset asserted while sending byte 2 of reg 5 -> tx_valid, busy and halt_req are 0 the next cycle; a following start restarts from reg 0, byte 00.
REQ-036 Ignored start: start pulses during SEND -> byte count still 128 with exactly one done pulse.
